// File: rtl/seg7_pkg.sv
// Shared types, character codes and glyph decode for the 7-segment display family.
package seg7_pkg;

  typedef logic [4:0] char_t;

  localparam char_t      CHAR_BLANK = 5'd16;
  localparam char_t      CHAR_DASH  = 5'd17;
  localparam logic [7:0] SEG_OFF    = 8'hFF;

  // Active-low segment byte for a character code; bit7 (dp) is always off.
  function automatic logic [7:0] glyph(input char_t code);
    logic [7:0] s;
    s = SEG_OFF;
    case (code)
      5'h00:      s = 8'hC0;
      5'h01:      s = 8'hF9;
      5'h02:      s = 8'hA4;
      5'h03:      s = 8'hB0;
      5'h04:      s = 8'h99;
      5'h05:      s = 8'h92;
      5'h06:      s = 8'h82;
      5'h07:      s = 8'hF8;
      5'h08:      s = 8'h80;
      5'h09:      s = 8'h90;
      5'h0A:      s = 8'h88;
      5'h0B:      s = 8'h83;
      5'h0C:      s = 8'hC6;
      5'h0D:      s = 8'hA1;
      5'h0E:      s = 8'h86;
      5'h0F:      s = 8'h8E;
      CHAR_BLANK: s = SEG_OFF;
      CHAR_DASH:  s = 8'hBF;
      default:    s = SEG_OFF;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_glyph_rom.sv
// Combinational character-code to active-low segment byte lookup.
module seg7_glyph_rom
  import seg7_pkg::*;
(
  input  char_t       code,
  output logic [7:0]  seg
);

  // Pure lookup; no state.
  always_comb seg = glyph(code);

endmodule

// File: rtl/seg7_scroll_driver.sv
// Multiplexed common-anode 7-segment driver with a scrolling message buffer.
// Everything runs on clk_27; slow_clk is only sampled and edge-detected.
module seg7_scroll_driver
  import seg7_pkg::*;
#(
  parameter  int NUM_DIGITS = 4,
  parameter  int MSG_LEN    = 16,
  parameter  int SCROLL_DIV = 250,
  localparam int ADDR_W     = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
)
(
  input  logic                  clk_27,
  input  logic                  rst,
  input  logic                  slow_clk,
  input  logic                  scroll_en,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  char_t                 wr_data,
  output logic [NUM_DIGITS-1:0] dig,
  output logic [7:0]            seg
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam int SUM_W = ADDR_W + 1;
  localparam logic [NUM_DIGITS-1:0] DIG_ONE = NUM_DIGITS'(1);

  logic              slow_sync_p0;
  logic              slow_sync_p1;
  logic              slow_prev_p2;
  logic              refresh_tick;
  logic [IDX_W-1:0]  dig_idx;
  logic [ADDR_W-1:0] scroll_off;
  logic [CNT_W-1:0]  tick_cnt;
  char_t             msg [MSG_LEN];
  logic [ADDR_W-1:0] msg_slot;
  char_t             char_sel;
  logic [7:0]        seg_next;

  // Next digit index, wrapping NUM_DIGITS-1 back to 0.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NUM_DIGITS - 1)) ? '0 : i + IDX_W'(1);
  endfunction

  // Next scroll offset, wrapping MSG_LEN-1 back to 0.
  function automatic logic [ADDR_W-1:0] next_off(input logic [ADDR_W-1:0] o);
    return (o == ADDR_W'(MSG_LEN - 1)) ? '0 : o + ADDR_W'(1);
  endfunction

  // (offset + index) mod MSG_LEN as compare-subtract; valid for any MSG_LEN.
  function automatic logic [ADDR_W-1:0] slot_of(input logic [ADDR_W-1:0] o,
                                                input logic [IDX_W-1:0]  i);
    logic [SUM_W-1:0] s;
    s = {1'b0, o} + SUM_W'(i);
    if (s >= SUM_W'(MSG_LEN))
      s = s - SUM_W'(MSG_LEN);
    return s[ADDR_W-1:0];
  endfunction

  // Stage p0/p1: two-flop synchronizer; p2: previous value for rising-edge detect.
  always_ff @(posedge clk_27 or negedge rst) begin
    if (!rst) begin
      slow_sync_p0 <= 1'b0;
      slow_sync_p1 <= 1'b0;
      slow_prev_p2 <= 1'b0;
    end else begin
      slow_sync_p0 <= slow_clk;
      slow_sync_p1 <= slow_sync_p0;
      slow_prev_p2 <= slow_sync_p1;
    end
  end

  assign refresh_tick = slow_sync_p1 & ~slow_prev_p2;

  // Digit scan and scroll offset advance, only ever on a refresh tick.
  always_ff @(posedge clk_27 or negedge rst) begin
    if (!rst) begin
      dig_idx    <= '0;
      scroll_off <= '0;
      tick_cnt   <= '0;
    end else if (refresh_tick) begin
      dig_idx <= next_idx(dig_idx);
      if (scroll_en) begin
        if (tick_cnt == CNT_W'(SCROLL_DIV - 1)) begin
          tick_cnt   <= '0;
          scroll_off <= next_off(scroll_off);
        end else begin
          tick_cnt <= tick_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Message buffer: reset to blanks, out-of-range write addresses dropped.
  always_ff @(posedge clk_27 or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MSG_LEN; i++)
        msg[i] <= CHAR_BLANK;
    end else if (wr_en && (32'(wr_addr) < MSG_LEN)) begin
      msg[wr_addr] <= wr_data;
    end
  end

  assign msg_slot = slot_of(scroll_off, dig_idx);
  assign char_sel = msg[msg_slot];

  seg7_glyph_rom u_glyph_rom (
    .code (char_sel),
    .seg  (seg_next)
  );

  // Output register: one cycle from index/offset/buffer to the pins.
  always_ff @(posedge clk_27 or negedge rst) begin
    if (!rst) begin
      dig <= '1;
      seg <= SEG_OFF;
    end else begin
      dig <= ~(DIG_ONE << dig_idx);
      seg <= seg_next;
    end
  end

endmodule

// File: tb/tb_seg7_scroll_driver.sv
// Bench for seg7_scroll_driver: a 16-slot and a 12-slot instance share all inputs.
module tb_seg7_scroll_driver;

  localparam int ND = 4;
  localparam int SD = 4;

  logic       clk_27    = 1'b0;
  logic       rst       = 1'b1;
  logic       slow_clk  = 1'b0;
  logic       scroll_en = 1'b0;
  logic       wr_en     = 1'b0;
  logic [3:0] wr_addr   = '0;
  logic [4:0] wr_data   = '0;
  logic [3:0] dig, dig12;
  logic [7:0] seg, seg12;

  seg7_scroll_driver #(.NUM_DIGITS(ND), .MSG_LEN(16), .SCROLL_DIV(SD)) u_dut (
    .clk_27(clk_27), .rst(rst), .slow_clk(slow_clk), .scroll_en(scroll_en),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .dig(dig), .seg(seg));

  seg7_scroll_driver #(.NUM_DIGITS(ND), .MSG_LEN(12), .SCROLL_DIV(SD)) u_dut12 (
    .clk_27(clk_27), .rst(rst), .slow_clk(slow_clk), .scroll_en(scroll_en),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .dig(dig12), .seg(seg12));

  always #5 clk_27 = ~clk_27;

  int tests = 0;
  int fails = 0;

  // Reference model: what is displayed, in terms of index, offset and message.
  int m_idx, m_cnt, m_off16, m_off12;
  int msg16 [16];
  int msg12 [12];
  logic [7:0] hex_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  function automatic logic [7:0] glyph_of(input int c);
    if (c < 16) return hex_tbl[c];
    if (c == 17) return 8'hBF;
    return 8'hFF;
  endfunction

  task automatic model_reset();
    m_idx = 0; m_cnt = 0; m_off16 = 0; m_off12 = 0;
    for (int i = 0; i < 16; i++) msg16[i] = 16;
    for (int i = 0; i < 12; i++) msg12[i] = 16;
  endtask

  task automatic model_tick();
    m_idx = (m_idx + 1) % ND;
    if (scroll_en) begin
      m_cnt++;
      if (m_cnt == SD) begin
        m_cnt   = 0;
        m_off16 = (m_off16 + 1) % 16;
        m_off12 = (m_off12 + 1) % 12;
      end
    end
  endtask

  task automatic model_wr(input int a, input int d);
    msg16[a] = d;
    if (a < 12) msg12[a] = d;
  endtask

  task automatic step();
    @(posedge clk_27);
    #1;
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check(input string tag);
    logic [3:0] ed;
    ed = ~(4'b0001 << m_idx);
    cmp({tag, "_dig"},   {28'd0, dig},   {28'd0, ed});
    cmp({tag, "_seg"},   {24'd0, seg},   {24'd0, glyph_of(msg16[(m_off16 + m_idx) % 16])});
    cmp({tag, "_dig12"}, {28'd0, dig12}, {28'd0, ed});
    cmp({tag, "_seg12"}, {24'd0, seg12}, {24'd0, glyph_of(msg12[(m_off12 + m_idx) % 12])});
  endtask

  // One slow_clk pulse; optional write lands in the same cycle as the refresh tick.
  task automatic tick(input string tag, input bit do_wr, input int a, input int d);
    slow_clk = 1'b1;
    step();
    step();
    if (do_wr) begin
      wr_en = 1'b1; wr_addr = a[3:0]; wr_data = d[4:0];
    end
    step();
    wr_en = 1'b0;
    check({tag, "_hold"});
    model_tick();
    if (do_wr) model_wr(a, d);
    step();
    check(tag);
    slow_clk = 1'b0;
    step(); step(); step();
  endtask

  task automatic wr(input int a, input int d);
    wr_en = 1'b1; wr_addr = a[3:0]; wr_data = d[4:0];
    step();
    wr_en = 1'b0;
    check("wr_hold");
    model_wr(a, d);
    step();
    check("wr");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ch;
    int n;
    logic [3:0] pd;
    model_reset();

    // Asynchronous reset takes effect with no clock edge.
    #1 rst = 1'b0;
    #1;
    cmp("rst_dig",   {28'd0, dig},   32'hF);
    cmp("rst_seg",   {24'd0, seg},   32'hFF);
    cmp("rst_dig12", {28'd0, dig12}, 32'hF);
    cmp("rst_seg12", {24'd0, seg12}, 32'hFF);
    step(); step();
    rst = 1'b1;
    step();
    cmp("post_rst_dig", {28'd0, dig}, 32'hE);
    cmp("post_rst_seg", {24'd0, seg}, 32'hFF);
    check("post_rst");

    // Load 0..15 (slots 12..15 are out of range for the 12-slot instance).
    for (int i = 0; i < 16; i++) wr(i, i);

    // Scan with scroll frozen.
    scroll_en = 1'b0;
    for (int i = 0; i < 5; i++) tick("scan", 1'b0, 0, 0);

    // Scroll: one step per SD ticks, run up to offset 15 on digit 0.
    scroll_en = 1'b1;
    for (int i = 0; i < 4; i++) tick("scroll", 1'b0, 0, 0);
    for (n = 0; n < 100 && !(m_off16 == 15 && m_idx == 0); n++) tick("scroll", 1'b0, 0, 0);
    scroll_en = 1'b0;
    cmp("off15_d0_seg", {24'd0, seg}, 32'h8E);
    tick("wrap", 1'b0, 0, 0);
    cmp("off15_d1_seg", {24'd0, seg}, 32'hC0);

    // Frozen offset over 20 ticks.
    for (int i = 0; i < 20; i++) tick("frozen", 1'b0, 0, 0);

    // Write to digit 0's slot in the same cycle as a refresh tick.
    tick("hazard", 1'b1, m_off16, 17);
    for (n = 0; n < 4 && m_idx != 0; n++) tick("hazard_scan", 1'b0, 0, 0);
    cmp("hazard_dash", {24'd0, seg}, 32'hBF);

    // Out-of-range address for the 12-slot instance.
    wr(13, $urandom_range(0, 15));
    for (int i = 0; i < 4; i++) tick("oor", 1'b0, 0, 0);

    // Scroll to offset 7, then pulse reset for half a cycle.
    scroll_en = 1'b1;
    for (n = 0; n < 200 && m_off16 != 7; n++) tick("to7", 1'b0, 0, 0);
    cmp("reach_off7", 32'(n < 200), 32'd1);
    rst = 1'b0;
    #1;
    cmp("midrst_dig", {28'd0, dig}, 32'hF);
    cmp("midrst_seg", {24'd0, seg}, 32'hFF);
    cmp("midrst_dig12", {28'd0, dig12}, 32'hF);
    #4 rst = 1'b1;
    model_reset();
    scroll_en = 1'b0;
    step();
    check("after_midrst");
    for (int i = 0; i < 4; i++) begin
      tick("blank_scan", 1'b0, 0, 0);
      cmp("blank_seg", {24'd0, seg}, 32'hFF);
    end

    // Long high level gives exactly one tick.
    ch = 0; pd = dig;
    slow_clk = 1'b1;
    repeat (100) begin step(); if (dig !== pd) ch++; pd = dig; end
    slow_clk = 1'b0;
    repeat (3) begin step(); if (dig !== pd) ch++; pd = dig; end
    cmp("hold_high_ticks", ch, 1);
    model_tick();
    check("hold_high");

    // Slow square wave: one tick per full period.
    ch = 0; pd = dig;
    repeat (27001) begin step(); if (dig !== pd) ch++; pd = dig; end
    slow_clk = 1'b1;
    repeat (27001) begin step(); if (dig !== pd) ch++; pd = dig; end
    slow_clk = 1'b0;
    repeat (3) begin step(); if (dig !== pd) ch++; pd = dig; end
    cmp("slow_wave_ticks", ch, 1);
    model_tick();
    check("slow_wave");

    // Randomized writes, scroll enables and tick spacing.
    for (int i = 0; i < 30; i++) begin
      scroll_en = 1'($urandom_range(0, 1));
      tick("rand", 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 31));
      repeat ($urandom_range(0, 3)) step();
      check("rand_gap");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
